chunked_adder_sub: RTL

- Parametrised, multi-cycle add/subtract unit; successor to the 4-bit ripple full-adder chain.
- Processes operands CHUNK bits per clock, LSB chunk first, carrying between chunks through a register. Long word widths therefore cost no long combinational carry path.
- start/busy/done handshake. Sits between operand registers and datapath consumers in lab ALU designs.

---
 rtl/chunked_adder_sub.sv | 124 ++++++++++++
 1 files changed

// File: rtl/chunked_adder_sub.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock, LSB chunk first, with the carry
// held in a register between chunks. Uses a start/busy/done handshake.
module chunked_adder_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, bp_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept, step, last;
    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_carry_in;

    // Carry into a chunk's top bit recovered from that bit's sum and operands,
    // which works for every CHUNK including 1.
    always_comb begin
        base         = 32'(cnt_q) * CHUNK;
        a_chunk      = a_q[base +: CHUNK];
        b_chunk      = bp_q[base +: CHUNK];
        chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        msb_carry_in = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, whatever the block ordering.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand and carry latches are not reset because every accept
    // overwrites them before they are read.
    always_ff @(posedge clock) begin
        if (accept) begin
            a_q     <= a;
            bp_q    <= sub ? ~b : b;
            carry_q <= sub ? ~c_in : c_in;
        end else if (step) begin
            carry_q <= chunk_sum[CHUNK];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s        <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done <= last;
            if (accept) begin
                s     <= '0;
                cnt_q <= '0;
                busy  <= 1'b1;
            end else if (step) begin
                s[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
                cnt_q            <= cnt_q + 1'b1;
                if (last) begin
                    c_out    <= chunk_sum[CHUNK];
                    overflow <= msb_carry_in ^ chunk_sum[CHUNK];
                    busy     <= 1'b0;
                end
            end
        end
    end

endmodule
